// File: rtl/alu_issue_decoder_pkg.sv
// Shared ALU issue definitions: op codes, MIPS opcode/funct constants
// and the decoded-entry bundle carried from issue into EX.
package alu_issue_decoder_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t OP_ADD  = 4'd0;
    localparam alu_op_t OP_ADDU = 4'd1;
    localparam alu_op_t OP_SUB  = 4'd2;
    localparam alu_op_t OP_SUBU = 4'd3;
    localparam alu_op_t OP_AND  = 4'd4;
    localparam alu_op_t OP_OR   = 4'd5;
    localparam alu_op_t OP_XOR  = 4'd6;
    localparam alu_op_t OP_NOR  = 4'd7;
    localparam alu_op_t OP_SLL  = 4'd8;
    localparam alu_op_t OP_SRL  = 4'd9;
    localparam alu_op_t OP_SRA  = 4'd10;
    localparam alu_op_t OP_NONE = 4'd12;

    localparam logic [5:0] OPC_R_TYPE = 6'h00;
    localparam logic [5:0] OPC_J      = 6'h02;
    localparam logic [5:0] OPC_JAL    = 6'h03;
    localparam logic [5:0] OPC_BEQ    = 6'h04;
    localparam logic [5:0] OPC_BNE    = 6'h05;
    localparam logic [5:0] OPC_ADDI   = 6'h08;
    localparam logic [5:0] OPC_ADDIU  = 6'h09;
    localparam logic [5:0] OPC_SLTI   = 6'h0A;
    localparam logic [5:0] OPC_ANDI   = 6'h0C;
    localparam logic [5:0] OPC_ORI    = 6'h0D;
    localparam logic [5:0] OPC_XORI   = 6'h0E;
    localparam logic [5:0] OPC_LUI    = 6'h0F;
    localparam logic [5:0] OPC_LW     = 6'h23;
    localparam logic [5:0] OPC_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_SRA  = 6'd3;
    localparam logic [5:0] FN_JR   = 6'd8;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_ADDU = 6'd33;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_SUBU = 6'd35;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_XOR  = 6'd38;
    localparam logic [5:0] FN_NOR  = 6'd39;
    localparam logic [5:0] FN_SLT  = 6'd42;

    typedef struct packed {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        wen;
        logic        slt;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
    } dec_t;

    localparam dec_t ENTRY_NONE = '{
        op: OP_NONE, a: 32'd0, b: 32'd0, dest: 5'd0,
        wen: 1'b0, slt: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0, illegal: 1'b0
    };

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'd0, v};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS decode into ALU op, operand selection and
// destination/enable flags for one instruction.
import alu_issue_decoder_pkg::*;

module alu_op_decode (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output dec_t        dec
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [31:0] shamt;
    logic [15:0] imm;
    logic        unused_rs_idx;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt_idx = instr[20:16];
    assign rd_idx = instr[15:11];
    assign shamt  = {27'd0, instr[10:6]};
    assign imm    = instr[15:0];
    // Register data arrives already read, so the rs index is not needed.
    assign unused_rs_idx = ^instr[25:21];

    always_comb begin
        dec = ENTRY_NONE;
        case (opcode)
            OPC_R_TYPE: begin
                dec.dest = rd_idx;
                case (funct)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        dec.op  = {1'b0, funct[2:0]};
                        dec.a   = rs;
                        dec.b   = rt;
                        dec.wen = 1'b1;
                    end
                    FN_SLT: begin
                        dec.op  = OP_SUB;
                        dec.slt = 1'b1;
                        dec.a   = rs;
                        dec.b   = rt;
                        dec.wen = 1'b1;
                    end
                    FN_SLL: begin
                        dec.op  = OP_SLL;
                        dec.a   = shamt;
                        dec.b   = rt;
                        dec.wen = 1'b1;
                    end
                    FN_SRL: begin
                        dec.op  = OP_SRL;
                        dec.a   = shamt;
                        dec.b   = rt;
                        dec.wen = 1'b1;
                    end
                    FN_SRA: begin
                        dec.op  = OP_SRA;
                        dec.a   = shamt;
                        dec.b   = rt;
                        dec.wen = 1'b1;
                    end
                    FN_JR: begin
                        dec.dest = 5'd0;
                    end
                    default: begin
                        dec.dest    = 5'd0;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            OPC_ADDI: begin
                dec.op   = OP_ADD;
                dec.a    = rs;
                dec.b    = sext16(imm);
                dec.dest = rt_idx;
                dec.wen  = 1'b1;
            end
            OPC_ADDIU: begin
                dec.op   = OP_ADDU;
                dec.a    = rs;
                dec.b    = sext16(imm);
                dec.dest = rt_idx;
                dec.wen  = 1'b1;
            end
            OPC_LW: begin
                dec.op     = OP_ADDU;
                dec.a      = rs;
                dec.b      = sext16(imm);
                dec.dest   = rt_idx;
                dec.wen    = 1'b1;
                dec.mem_rd = 1'b1;
            end
            OPC_SW: begin
                dec.op     = OP_ADDU;
                dec.a      = rs;
                dec.b      = sext16(imm);
                dec.dest   = rt_idx;
                dec.mem_wr = 1'b1;
            end
            OPC_SLTI: begin
                dec.op   = OP_SUB;
                dec.slt  = 1'b1;
                dec.a    = rs;
                dec.b    = sext16(imm);
                dec.dest = rt_idx;
                dec.wen  = 1'b1;
            end
            OPC_ANDI: begin
                dec.op   = OP_AND;
                dec.a    = rs;
                dec.b    = zext16(imm);
                dec.dest = rt_idx;
                dec.wen  = 1'b1;
            end
            OPC_ORI: begin
                dec.op   = OP_OR;
                dec.a    = rs;
                dec.b    = zext16(imm);
                dec.dest = rt_idx;
                dec.wen  = 1'b1;
            end
            OPC_XORI: begin
                dec.op   = OP_XOR;
                dec.a    = rs;
                dec.b    = zext16(imm);
                dec.dest = rt_idx;
                dec.wen  = 1'b1;
            end
            OPC_LUI: begin
                dec.op   = OP_SLL;
                dec.a    = 32'd16;
                dec.b    = zext16(imm);
                dec.dest = rt_idx;
                dec.wen  = 1'b1;
            end
            OPC_BEQ, OPC_BNE: begin
                dec.op = OP_SUB;
                dec.a  = rs;
                dec.b  = rt;
            end
            OPC_JAL: begin
                dec.op   = OP_ADDU;
                dec.a    = pc;
                dec.b    = 32'd8;
                dec.dest = 5'd31;
                dec.wen  = 1'b1;
            end
            OPC_J: begin
                dec.op = OP_NONE;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        // $0 is hardwired, so a write to it is never enabled.
        if (dec.dest == 5'd0) dec.wen = 1'b0;
    end

endmodule

// File: rtl/alu_issue_decoder.sv
// ALU issue stage: decodes incoming instructions and holds them in a
// main + skid ID/EX buffer with valid/ready on both sides.
import alu_issue_decoder_pkg::*;

module alu_issue_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [4:0]  out_dest,
    output logic        out_wen,
    output logic        out_slt,
    output logic        out_mem_rd,
    output logic        out_mem_wr,
    output logic        out_illegal
);

    dec_t dec;
    dec_t main_q;
    dec_t skid_q;
    logic main_v;
    logic skid_v;
    logic accept;
    logic drain;

    alu_op_decode u_decode (
        .instr (in_instr),
        .pc    (in_pc),
        .rs    (in_rs_data),
        .rt    (in_rt_data),
        .dec   (dec)
    );

    // in_ready comes straight from a flop, never from out_ready.
    assign in_ready = ~skid_v;
    assign accept   = in_valid & in_ready;
    assign drain    = main_v & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q <= ENTRY_NONE;
            skid_q <= ENTRY_NONE;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (drain && skid_v) begin
            main_q <= skid_q;
            skid_v <= 1'b0;
        end else if (accept && (!main_v || drain)) begin
            main_q <= dec;
            main_v <= 1'b1;
        end else if (accept) begin
            skid_q <= dec;
            skid_v <= 1'b1;
        end else if (drain) begin
            main_v <= 1'b0;
        end
    end

    assign out_valid   = main_v;
    assign out_op      = main_q.op;
    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign out_dest    = main_q.dest;
    assign out_wen     = main_q.wen;
    assign out_slt     = main_q.slt;
    assign out_mem_rd  = main_q.mem_rd;
    assign out_mem_wr  = main_q.mem_wr;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Testbench for alu_issue_decoder: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_alu_issue_decoder;
    import alu_issue_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_dest;
    logic        out_wen;
    logic        out_slt;
    logic        out_mem_rd;
    logic        out_mem_wr;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    dec_t mq[$];
    dec_t dut_log[$];
    bit   acc_f;

    alu_issue_decoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_a(out_a), .out_b(out_b),
        .out_dest(out_dest), .out_wen(out_wen), .out_slt(out_slt),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    function automatic dec_t dut_entry();
        return '{op: out_op, a: out_a, b: out_b, dest: out_dest,
                 wen: out_wen, slt: out_slt, mem_rd: out_mem_rd,
                 mem_wr: out_mem_wr, illegal: out_illegal};
    endfunction

    // Reference decode written directly from the instruction-set rules.
    function automatic dec_t ref_decode(logic [31:0] i, logic [31:0] pc,
                                        logic [31:0] rs, logic [31:0] rt);
        dec_t d;
        int opc, fn;
        logic [31:0] sx, zx;
        opc = int'(i[31:26]);
        fn  = int'(i[5:0]);
        sx  = 32'($signed(i[15:0]));
        zx  = 32'(i[15:0]);
        d = '0;
        d.op = 4'd12;
        if (opc == 0) begin
            if (fn >= 32 && fn <= 39) begin
                d.op = 4'(fn - 32); d.a = rs; d.b = rt;
                d.dest = i[15:11]; d.wen = 1;
            end else if (fn == 42) begin
                d.op = 4'd2; d.slt = 1; d.a = rs; d.b = rt;
                d.dest = i[15:11]; d.wen = 1;
            end else if (fn == 0 || fn == 2 || fn == 3) begin
                d.op = (fn == 0) ? 4'd8 : (fn == 2) ? 4'd9 : 4'd10;
                d.a = 32'(i[10:6]); d.b = rt;
                d.dest = i[15:11]; d.wen = 1;
            end else if (fn != 8) begin
                d.illegal = 1;
            end
        end else begin
            case (opc)
                2: ;
                3: begin d.op = 4'd1; d.a = pc; d.b = 8; d.dest = 31; d.wen = 1; end
                4, 5: begin d.op = 4'd2; d.a = rs; d.b = rt; end
                8:  begin d.op = 4'd0; d.a = rs; d.b = sx; d.dest = i[20:16]; d.wen = 1; end
                9:  begin d.op = 4'd1; d.a = rs; d.b = sx; d.dest = i[20:16]; d.wen = 1; end
                35: begin d.op = 4'd1; d.a = rs; d.b = sx; d.dest = i[20:16]; d.wen = 1; d.mem_rd = 1; end
                43: begin d.op = 4'd1; d.a = rs; d.b = sx; d.dest = i[20:16]; d.mem_wr = 1; end
                10: begin d.op = 4'd2; d.slt = 1; d.a = rs; d.b = sx; d.dest = i[20:16]; d.wen = 1; end
                12: begin d.op = 4'd4; d.a = rs; d.b = zx; d.dest = i[20:16]; d.wen = 1; end
                13: begin d.op = 4'd5; d.a = rs; d.b = zx; d.dest = i[20:16]; d.wen = 1; end
                14: begin d.op = 4'd6; d.a = rs; d.b = zx; d.dest = i[20:16]; d.wen = 1; end
                15: begin d.op = 4'd8; d.a = 16; d.b = zx; d.dest = i[20:16]; d.wen = 1; end
                default: d.illegal = 1;
            endcase
        end
        if (d.dest == 0) d.wen = 0;
        return d;
    endfunction

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(int opc, int rs, int rt, logic [15:0] imm);
        return {6'(opc), 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        int opcs[16] = '{0, 0, 0, 2, 3, 4, 5, 8, 9, 10, 12, 13, 14, 15, 35, 43};
        int fns[14]  = '{0, 2, 3, 8, 32, 33, 34, 35, 36, 37, 38, 39, 42, 0};
        int opc, fn, r1, r2, r3;
        if ($urandom_range(0, 9) == 0) return $urandom;
        opc = opcs[$urandom_range(0, 15)];
        fn  = fns[$urandom_range(0, 13)];
        if ($urandom_range(0, 9) == 0) fn = $urandom_range(0, 63);
        r1 = $urandom_range(0, 31);
        r2 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 31);
        r3 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 31);
        if (opc == 0) return enc_r(r1, r2, r3, $urandom_range(0, 31), fn);
        return enc_i(opc, r1, r2, 16'($urandom));
    endfunction

    task automatic drive(logic [31:0] i, logic [31:0] pc,
                         logic [31:0] rs, logic [31:0] rt, logic v);
        in_instr = i; in_pc = pc; in_rs_data = rs; in_rt_data = rt;
        in_valid = v;
    endtask

    // Advance one clock and step the two-deep in-order model.
    task automatic tick();
        bit rdy, drn;
        acc_f = 0;
        if (rst_n && !flush && out_valid && out_ready)
            dut_log.push_back(dut_entry());
        @(posedge clk);
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            rdy = mq.size() < 2;
            drn = mq.size() > 0 && out_ready;
            if (drn) void'(mq.pop_front());
            if (in_valid && rdy) begin
                mq.push_back(ref_decode(in_instr, in_pc, in_rs_data, in_rt_data));
                acc_f = 1;
            end
        end
        #1;
    endtask

    task automatic empty_pipe();
        in_valid = 0; out_ready = 1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        checks++;
        if (out_op !== 4'd12 || out_a !== 0 || out_b !== 0 || out_dest !== 0 ||
            {out_wen, out_slt, out_mem_rd, out_mem_wr, out_illegal} !== 5'b0) begin
            errors++;
            $display("FAIL reset_data: op=%0d a=%h b=%h dest=%0d want op 12, zeros",
                     out_op, out_a, out_b, out_dest);
        end
    endtask

    task automatic test_addi();
        out_ready = 1;
        drive(enc_i(8, 1, 2, 16'hFFFF), 32'h100, 32'd5, 32'd0, 1);
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1 || out_op !== 4'd0 || out_a !== 32'd5 ||
            out_b !== 32'hFFFFFFFF || out_dest !== 5'd2 || out_wen !== 1) begin
            errors++;
            $display("FAIL addi: v=%b op=%0d a=%h b=%h dest=%0d wen=%b want 1/0/5/ffffffff/2/1",
                     out_valid, out_op, out_a, out_b, out_dest, out_wen);
        end
        tick();
    endtask

    task automatic test_sra_lui();
        out_ready = 1;
        drive(enc_r(0, 4, 3, 4, 3), 32'h200, 32'h0, 32'h80000000, 1);
        tick();
        checks++;
        if (out_op !== 4'd10 || out_a !== 32'd4 || out_b !== 32'h80000000 ||
            out_dest !== 5'd3) begin
            errors++;
            $display("FAIL sra: op=%0d a=%h b=%h dest=%0d want 10/4/80000000/3",
                     out_op, out_a, out_b, out_dest);
        end
        drive(enc_i(15, 0, 5, 16'h1234), 32'h204, 32'h77, 32'h0, 1);
        tick();
        in_valid = 0;
        checks++;
        if (out_op !== 4'd8 || out_a !== 32'd16 || out_b !== 32'h00001234 ||
            out_dest !== 5'd5 || out_wen !== 1) begin
            errors++;
            $display("FAIL lui: op=%0d a=%h b=%h dest=%0d want 8/10/1234/5",
                     out_op, out_a, out_b, out_dest);
        end
        tick();
    endtask

    task automatic test_wen_illegal();
        out_ready = 1;
        drive(enc_i(13, 0, 0, 16'h7), 32'h300, 32'h0, 32'h0, 1);
        tick();
        checks++;
        if (out_wen !== 0 || out_op !== 4'd5 || out_b !== 32'd7) begin
            errors++;
            $display("FAIL ori_r0: wen=%b op=%0d b=%h want 0/5/7", out_wen, out_op, out_b);
        end
        drive(32'hFC00_0000 | 32'h0012_3456, 32'h304, 32'h1, 32'h2, 1);
        tick();
        in_valid = 0;
        checks++;
        if (out_illegal !== 1 || out_op !== 4'd12 || out_wen !== 0 ||
            out_a !== 0 || out_b !== 0) begin
            errors++;
            $display("FAIL illegal: ill=%b op=%0d wen=%b a=%h b=%h want 1/12/0/0/0",
                     out_illegal, out_op, out_wen, out_a, out_b);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ia, ib, ic;
        dec_t exp[3];
        int n;
        ia = enc_r(1, 2, 7, 0, 33);
        ib = enc_i(9, 3, 8, 16'h8000);
        ic = enc_i(3, 0, 0, 16'h0040);
        exp[0] = ref_decode(ia, 32'h400, 32'h11, 32'h22);
        exp[1] = ref_decode(ib, 32'h404, 32'h33, 32'h44);
        exp[2] = ref_decode(ic, 32'h408, 32'h55, 32'h66);
        empty_pipe();
        dut_log.delete();
        out_ready = 0;
        drive(ia, 32'h400, 32'h11, 32'h22, 1);
        tick();
        drive(ib, 32'h404, 32'h33, 32'h44, 1);
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready: in_ready=%b want 0", in_ready);
        end
        drive(ic, 32'h408, 32'h55, 32'h66, 1);
        tick();
        checks++;
        if (out_valid !== 1 || dut_entry() !== exp[0]) begin
            errors++;
            $display("FAIL b2b_stall: got %h want %h", dut_entry(), exp[0]);
        end
        out_ready = 1;
        n = 0;
        do begin tick(); n++; end while (!acc_f && n < 10);
        in_valid = 0;
        checks++;
        if (!acc_f) begin
            errors++;
            $display("FAIL b2b_accept_timeout: third instruction not taken in %0d cycles", n);
        end
        n = 0;
        while (out_valid === 1'b1 && n < 10) begin tick(); n++; end
        checks++;
        if (dut_log.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d entries want 3", dut_log.size());
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k >= dut_log.size() || dut_log[k] !== exp[k]) begin
                errors++;
                $display("FAIL b2b_order[%0d]: got %h want %h", k,
                         (k < dut_log.size()) ? dut_log[k] : dec_t'('0), exp[k]);
            end
        end
    endtask

    task automatic test_flush();
        empty_pipe();
        out_ready = 0;
        drive(enc_i(8, 1, 9, 16'h1), 32'h500, 32'h1, 32'h0, 1);
        tick();
        drive(enc_i(8, 1, 10, 16'h2), 32'h504, 32'h1, 32'h0, 1);
        tick();
        flush = 1;
        drive(enc_i(8, 1, 11, 16'h3), 32'h508, 32'h1, 32'h0, 1);
        tick();
        flush = 0;
        in_valid = 0;
        checks++;
        if (out_valid !== 0 || in_ready !== 1) begin
            errors++;
            $display("FAIL flush_state: valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        dut_log.delete();
        out_ready = 1;
        repeat (3) tick();
        checks++;
        if (dut_log.size() != 0 || out_valid !== 0) begin
            errors++;
            $display("FAIL flush_leak: %0d entries delivered, valid=%b want 0/0",
                     dut_log.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        empty_pipe();
        out_ready = 0;
        drive(enc_r(1, 2, 3, 0, 36), 32'h600, 32'hF0, 32'h0F, 1);
        tick();
        drive(enc_r(1, 2, 4, 0, 37), 32'h604, 32'hF0, 32'h0F, 1);
        tick();
        in_valid = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        checks++;
        if (out_valid !== 0 || out_op !== 4'd12 || in_ready !== 1 ||
            out_a !== 0 || out_dest !== 0) begin
            errors++;
            $display("FAIL reset_stall: v=%b op=%0d ready=%b a=%h dest=%0d want 0/12/1/0/0",
                     out_valid, out_op, in_ready, out_a, out_dest);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 800; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive(rand_instr(), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  $urandom, $urandom, $urandom_range(0, 2) != 0);
            tick();
            checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL rand_hs @%0d: valid=%b ready=%b want %b/%b", c,
                             out_valid, in_ready, mq.size() > 0, mq.size() < 2);
            end
            if (mq.size() > 0) begin
                checks++;
                if (dut_entry() !== mq[0]) begin
                    errors++;
                    if (bad++ < 10)
                        $display("FAIL rand_data @%0d: got %h want %h", c,
                                 dut_entry(), mq[0]);
                end
            end
        end
        rst_n = 1;
        flush = 0;
        in_valid = 0;
    endtask

    initial begin
        rst_n = 0; flush = 0; out_ready = 0;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 0);
        test_reset();
        test_addi();
        test_sra_lui();
        test_wen_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
